// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone burst master; cmd_* request in, wb_* bus out/in, rd_*/checksum read results, done/err status
module wb_burst_master #(
  parameter int A_WIDTH = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [A_WIDTH:0]   cmd_addr,
  input  logic [A_WIDTH:0]   cmd_len,
  input  logic [3:0]         cmd_be,
  input  logic [31:0]        cmd_seed,
  output logic               wb_stb_o,
  output logic [A_WIDTH:0]   wb_addr_o,
  output logic [3:0]         wb_we_o,
  output logic [31:0]        wb_data_o,
  input  logic               wb_ack_i,
  input  logic               wb_stall_i,
  input  logic [31:0]        wb_data_i,
  output logic               rd_valid,
  output logic [31:0]        rd_data,
  output logic [A_WIDTH:0]   rd_index,
  output logic [31:0]        checksum,
  output logic               done,
  output logic               err
);
  localparam int AW = A_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic write_r, pend, accept, beat, last, tout;
  logic [AW-1:0] len_r, idx, pend_idx;
  logic [TW-1:0] tcnt;
  assign cmd_ready = state == IDLE && !rst;
  assign accept = cmd_valid && cmd_ready;
  assign wb_stb_o = state == ISSUE;
  assign done = state == DONE;
  assign beat = wb_stb_o && wb_ack_i && !wb_stall_i;
  assign last = idx == len_r - AW'(1);
  assign tout = wb_stb_o && !beat && tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (accept ? (cmd_len != '0 ? ISSUE : DONE) : IDLE)
            : state == ISSUE ? (beat && last ? (write_r ? DONE : DRAIN) : (tout ? DONE : ISSUE))
            : state == DRAIN ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      write_r   <= 1'b0;
      len_r     <= '0;
      idx       <= '0;
      tcnt      <= '0;
      pend      <= 1'b0;
      pend_idx  <= '0;
      wb_addr_o <= '0;
      wb_we_o   <= '0;
      wb_data_o <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_index  <= '0;
      checksum  <= '0;
      err       <= 1'b0;
    end else begin
      state    <= state_n;
      pend     <= beat && !write_r;
      pend_idx <= idx;
      rd_valid <= pend;
      if (pend) begin
        rd_data  <= wb_data_i;
        rd_index <= pend_idx;
      end
      if (accept) begin
        write_r   <= cmd_write;
        len_r     <= cmd_len;
        wb_addr_o <= cmd_addr;
        wb_data_o <= cmd_seed;
        wb_we_o   <= cmd_write ? cmd_be : 4'b0000;
        idx       <= '0;
        tcnt      <= '0;
        err       <= 1'b0;
        checksum  <= '0;
      end else begin
        if (pend) checksum <= checksum + wb_data_i;
        if (beat) begin
          wb_addr_o <= wb_addr_o + AW'(1);
          wb_data_o <= wb_data_o + 32'd1;
          idx       <= idx + AW'(1);
          tcnt      <= '0;
        end else if (wb_stb_o) tcnt <= tcnt + TW'(1);
        if (tout) err <= 1'b1;
      end
    end
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter A_WIDTH, default 8: RAM-select bit is bit A_WIDTH of the address; address width is A_WIDTH+1.
REQ-002 SHALL have parameter TIMEOUT, default 15: consecutive non-accepted strobe cycles before abort.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  A_WIDTH+1  start word address.
REQ-009 cmd_len  in  A_WIDTH+1  beat count; 0 = no beats.
REQ-010 cmd_be  in  4  byte-enable mask for write beats.
REQ-011 cmd_seed  in  32  write data of beat 0; beat i carries cmd_seed+i mod 2^32.
REQ-012 wb_stb_o  out  1  Wishbone strobe.
REQ-013 wb_addr_o  out  A_WIDTH+1  beat address.
REQ-014 wb_we_o  out  4  cmd_be on write bursts, 4'b0000 on reads.
REQ-015 wb_data_o  out  32  write data.
REQ-016 wb_ack_i  in  1  responder ack, same cycle as accepted strobe.
REQ-017 wb_stall_i  in  1  responder stall.
REQ-018 wb_data_i  in  32  read data, valid the cycle after ack.
REQ-019 rd_valid  out  1  one-cycle pulse, rd_data/rd_index valid.
REQ-020 rd_data  out  32  captured read word.
REQ-021 rd_index  out  A_WIDTH+1  beat index of rd_data.
REQ-022 checksum  out  32  sum of read words of the current/last burst, mod 2^32.
REQ-023 done  out  1  one-cycle pulse at burst end.
REQ-024 err  out  1  set on timeout abort; held until next command acceptance.

Function
REQ-025 States SHALL be IDLE, ISSUE, DRAIN, DONE, all registered.
REQ-026 IDLE: on accept, latch all cmd_* fields, clear checksum, err, beat counter, timeout counter; go ISSUE if cmd_len != 0, else DONE.
REQ-027 ISSUE: wb_stb_o=1, wb_addr_o=current address, wb_data_o=cmd_seed+beat index, wb_we_o per REQ-014.
REQ-028 Beat accepted SHALL be wb_ack_i && !wb_stall_i while wb_stb_o=1; address, data and beat counter advance next cycle.
REQ-029 Address SHALL increment by 1 per beat, wrapping modulo 2^(A_WIDTH+1) (crosses RAM-select bit freely).
REQ-030 Stalled or un-acked cycles SHALL hold address, data and we unchanged.
REQ-031 Read beat accepted in cycle N: wb_data_i SHALL be captured at end of cycle N+1; rd_valid high in cycle N+2 with rd_index = that beat's index; checksum updated same edge.
REQ-032 Back-to-back read acks SHALL each produce one rd_valid pulse, no loss.
REQ-033 After last beat accepted: write -> DONE; read -> DRAIN (one cycle, wb_stb_o=0, captures final word) -> DONE.
REQ-034 DONE: done=1 for one cycle, wb_stb_o=0, then IDLE.
REQ-035 Timeout counter SHALL count consecutive non-accepted ISSUE cycles, clear on acceptance; on reaching TIMEOUT: wb_stb_o drops next cycle, err=1, go DONE (pending read still captured).
REQ-036 cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-037 While rst=1 (asynchronous): state IDLE, wb_stb_o=0, wb_we_o=0, wb_addr_o=0, wb_data_o=0, rd_valid=0, rd_data=0, rd_index=0, checksum=0, done=0, err=0, cmd_ready=0 during reset and 1 from first cycle after release.
REQ-038 Reset mid-burst SHALL abort immediately; no rd_valid or done pulse for the aborted burst.

Verification
REQ-039 Write burst addr=0x0FE, len=4, seed=0x10, be=4'hF, no stall -> beats at 0x0FE,0x0FF,0x100,0x101 with data 0x10..0x13, done 5 cycles after accept.
REQ-040 Read burst addr=0x1FF, len=2, responder returns 0xA,0xB -> addresses 0x1FF,0x000; rd_valid twice, indices 0,1; checksum=0x15; done after DRAIN.
REQ-041 Read len=3 with wb_stall_i high 2 cycles on beat 1 -> beat 1 address held 3 cycles, exactly 3 rd_valid pulses, order preserved.
REQ-042 Responder never acks, TIMEOUT=15 -> wb_stb_o high 15 cycles, err=1, done pulse, cmd_ready returns.
REQ-043 cmd_len=0 -> no strobe, done one cycle after accept, err=0.
REQ-044 rst asserted during beat 2 of len=8 read -> wb_stb_o low same cycle, no done, new command accepted after release.
